// File: rtl/db_line_server_if.sv
// db_line_server_if: load request / line return handshake between the
// seed-extension FSM (master) and the database line server (slave).
`default_nettype none

interface db_line_server_if;
  logic         load;
  logic [31:0]  addrIn;
  logic         dbReload;
  logic         loadDone;
  logic         dataValid;
  logic [511:0] dbData;
  logic         addrErr;

  modport master (
    output load, addrIn, dbReload,
    input  loadDone, dataValid, dbData, addrErr
  );

  modport slave (
    input  load, addrIn, dbReload,
    output loadDone, dataValid, dbData, addrErr
  );
endinterface

`default_nettype wire

// File: rtl/db_line_server.sv
// ==== db_line_server : bit-address to 512-bit line fetch with one-line hit buffer (rev 1.0) ====
`default_nettype none

module db_line_server #(
  parameter int MEM_LAT  = 2,
  parameter int DB_LINES = 4096,
  parameter int LINE_AW  = 12
) (
  input  logic               clk,
  input  logic               rst,
  db_line_server_if.slave    bus,
  output logic               memRdEn,
  output logic [LINE_AW-1:0] memRdAddr,
  input  logic [511:0]       memRdData,
  output logic [15:0]        reqCount
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACK   = 3'd1,
    S_FETCH = 3'd2,
    S_DATA  = 3'd3,
    S_REARM = 3'd4
  } state_t;

  state_t       state;
  logic [22:0]  line_q;
  logic         path_err;
  logic         path_hit;
  logic [CNT_W-1:0] fetch_cnt;

  logic         buf_valid;
  logic [22:0]  buf_tag;
  logic [511:0] buf_data;

  logic         load_done_q;
  logic         data_valid_q;
  logic         addr_err_q;
  logic [511:0] db_data_q;

  logic [22:0]  new_line;
  logic         new_err;
  logic         new_hit;
  logic         unused_offset;

  assign new_line      = bus.addrIn[31:9];
  assign new_err       = 32'(new_line) >= 32'(DB_LINES);
  assign new_hit       = buf_valid && (buf_tag == new_line) && !bus.dbReload;
  assign unused_offset = ^bus.addrIn[8:0];

  assign bus.loadDone  = load_done_q;
  assign bus.dataValid = data_valid_q;
  assign bus.addrErr   = addr_err_q;
  assign bus.dbData    = db_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      line_q       <= '0;
      path_err     <= 1'b0;
      path_hit     <= 1'b0;
      fetch_cnt    <= '0;
      buf_valid    <= 1'b0;
      buf_tag      <= '0;
      buf_data     <= '0;
      load_done_q  <= 1'b0;
      data_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      db_data_q    <= '0;
      memRdEn      <= 1'b0;
      memRdAddr    <= '0;
      reqCount     <= '0;
    end else begin
      load_done_q  <= 1'b0;
      data_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      memRdEn      <= 1'b0;

      // A reload drops the buffer; a fill completing on this same edge overrides it below.
      if (bus.dbReload) begin
        buf_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (bus.load) begin
            line_q      <= new_line;
            path_err    <= new_err;
            path_hit    <= !new_err && new_hit;
            reqCount    <= reqCount + 16'd1;
            load_done_q <= 1'b1;
            fetch_cnt   <= CNT_W'(1);
            if (!new_err && !new_hit) begin
              memRdEn   <= 1'b1;
              memRdAddr <= new_line[LINE_AW-1:0];
            end
            state <= S_ACK;
          end
        end

        S_ACK: begin
          if (path_err) begin
            db_data_q    <= '0;
            data_valid_q <= 1'b1;
            addr_err_q   <= 1'b1;
            state        <= S_DATA;
          end else if (path_hit && !bus.dbReload) begin
            db_data_q    <= buf_data;
            data_valid_q <= 1'b1;
            state        <= S_DATA;
          end else if (path_hit) begin
            // Reload landed while acknowledging a hit: refetch instead of serving stale data.
            memRdEn   <= 1'b1;
            memRdAddr <= line_q[LINE_AW-1:0];
            fetch_cnt <= CNT_W'(1);
            state     <= S_FETCH;
          end else begin
            state <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (fetch_cnt == CNT_W'(MEM_LAT)) begin
            db_data_q    <= memRdData;
            buf_data     <= memRdData;
            buf_tag      <= line_q;
            buf_valid    <= 1'b1;
            data_valid_q <= 1'b1;
            state        <= S_DATA;
          end else begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          state <= bus.load ? S_REARM : S_IDLE;
        end

        S_REARM: begin
          if (!bus.load) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_db_line_server.sv
// tb_db_line_server: scoreboard bench for db_line_server with a fixed-latency RAM model.
`default_nettype none

module tb_db_line_server;
  localparam int MEM_LAT  = 2;
  localparam int DB_LINES = 4096;
  localparam int LINE_AW  = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  db_line_server_if bus();
  logic               memRdEn;
  logic [LINE_AW-1:0] memRdAddr;
  logic [511:0]       memRdData;
  logic [15:0]        reqCount;

  db_line_server #(
    .MEM_LAT (MEM_LAT),
    .DB_LINES(DB_LINES),
    .LINE_AW (LINE_AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .memRdEn  (memRdEn),
    .memRdAddr(memRdAddr),
    .memRdData(memRdData),
    .reqCount (reqCount)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [511:0] data;
    logic         err;
    int           lat;
  } exp_t;
  exp_t sb[$];

  logic        m_valid = 1'b0;
  logic [22:0] m_tag   = '0;
  logic [15:0] m_count = '0;

  function automatic logic [511:0] pat(input logic [11:0] l);
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[i*32 +: 32] = {8'hA5, 4'(i), 8'h3C, l};
    return p;
  endfunction

  // RAM model: data appears MEM_LAT cycles after the memRdEn cycle, garbage otherwise.
  logic               pipe_v [MEM_LAT];
  logic [LINE_AW-1:0] pipe_a [MEM_LAT];
  always @(posedge clk) begin
    pipe_v[0] <= memRdEn;
    pipe_a[0] <= memRdAddr;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
  end
  assign memRdData = pipe_v[MEM_LAT-1] ? pat(pipe_a[MEM_LAT-1]) : {16{32'hBAD0_BAD0}};

  task automatic test_reset();
    rst = 1'b0;
    bus.load = 1'b0; bus.addrIn = '0; bus.dbReload = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.loadDone !== 1'b0)  begin errors++; $display("FAIL reset_loadDone got %b want 0", bus.loadDone); end
    checks++; if (bus.dataValid !== 1'b0) begin errors++; $display("FAIL reset_dataValid got %b want 0", bus.dataValid); end
    checks++; if (bus.addrErr !== 1'b0)   begin errors++; $display("FAIL reset_addrErr got %b want 0", bus.addrErr); end
    checks++; if (memRdEn !== 1'b0)       begin errors++; $display("FAIL reset_memRdEn got %b want 0", memRdEn); end
    checks++; if (memRdAddr !== '0)       begin errors++; $display("FAIL reset_memRdAddr got %0h want 0", memRdAddr); end
    checks++; if (bus.dbData !== '0)      begin errors++; $display("FAIL reset_dbData got %0h want 0", bus.dbData); end
    checks++; if (reqCount !== 16'd0)     begin errors++; $display("FAIL reset_reqCount got %0d want 0", reqCount); end
    rst = 1'b1;
    m_valid = 1'b0; m_count = '0;
  endtask

  task automatic test_request(input string name, input logic [31:0] addr, input int hold);
    logic [22:0] line;
    logic        err, hit, miss;
    exp_t        e;
    int          nld, nmem, ndv, span;
    nld = 0; nmem = 0; ndv = 0;
    line = addr[31:9];
    err  = (line >= 23'(DB_LINES));
    hit  = !err && m_valid && (m_tag == line);
    miss = !err && !hit;
    e.err  = err;
    e.data = err ? '0 : pat(line[11:0]);
    e.lat  = miss ? 2 + MEM_LAT : 2;
    sb.push_back(e);
    if (miss) begin m_valid = 1'b1; m_tag = line; end
    m_count = m_count + 16'd1;
    span = ((hold > e.lat) ? hold : e.lat) + 3;

    @(negedge clk);
    bus.load = 1'b1; bus.addrIn = addr;
    @(posedge clk);
    for (int c = 1; c <= span; c++) begin
      #1;
      if (c == 1) bus.addrIn = $urandom;
      if (bus.loadDone) begin
        nld++;
        checks++; if (c != 1) begin errors++; $display("FAIL %s loadDone_cycle got T+%0d want T+1", name, c); end
      end
      if (memRdEn) begin
        nmem++;
        checks++;
        if (c != 1 || memRdAddr !== line[LINE_AW-1:0]) begin
          errors++; $display("FAIL %s memRd got T+%0d addr %0h want T+1 addr %0h", name, c, memRdAddr, line[LINE_AW-1:0]);
        end
      end
      if (bus.dataValid) begin
        ndv++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL %s unexpected_dataValid at T+%0d", name, c);
        end else begin
          exp_t x;
          x = sb.pop_front();
          if (c != x.lat) begin errors++; $display("FAIL %s dataValid_cycle got T+%0d want T+%0d", name, c, x.lat); end
          checks++; if (bus.dbData !== x.data) begin errors++; $display("FAIL %s dbData got %0h want %0h", name, bus.dbData, x.data); end
          checks++; if (bus.addrErr !== x.err) begin errors++; $display("FAIL %s addrErr got %b want %b", name, bus.addrErr, x.err); end
        end
      end
      if (c >= hold) bus.load = 1'b0;
      @(posedge clk);
    end
    checks++; if (nld != 1)          begin errors++; $display("FAIL %s loadDone_count got %0d want 1", name, nld); end
    checks++; if (nmem != int'(miss)) begin errors++; $display("FAIL %s memRdEn_count got %0d want %0d", name, nmem, int'(miss)); end
    checks++; if (ndv != 1)          begin errors++; $display("FAIL %s dataValid_count got %0d want 1", name, ndv); end
    checks++; if (reqCount !== m_count) begin errors++; $display("FAIL %s reqCount got %0d want %0d", name, reqCount, m_count); end
    sb.delete();
  endtask

  task automatic test_reload();
    @(negedge clk); bus.dbReload = 1'b1;
    @(negedge clk); bus.dbReload = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    int ndv;
    ndv = 0;
    @(negedge clk);
    bus.load = 1'b1; bus.addrIn = 32'h0000_0E00;
    @(posedge clk); #1;
    checks++; if (memRdEn !== 1'b1) begin errors++; $display("FAIL midfetch_memRdEn got %b want 1", memRdEn); end
    @(posedge clk); #1;
    rst = 1'b0; bus.load = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++; if (bus.loadDone !== 1'b0 || bus.dataValid !== 1'b0 || bus.addrErr !== 1'b0) begin
      errors++; $display("FAIL midfetch_flags got ld=%b dv=%b ae=%b want 0", bus.loadDone, bus.dataValid, bus.addrErr);
    end
    checks++; if (memRdEn !== 1'b0 || memRdAddr !== '0) begin errors++; $display("FAIL midfetch_mem got en=%b addr=%0h want 0", memRdEn, memRdAddr); end
    checks++; if (bus.dbData !== '0) begin errors++; $display("FAIL midfetch_dbData got %0h want 0", bus.dbData); end
    checks++; if (reqCount !== 16'd0) begin errors++; $display("FAIL midfetch_reqCount got %0d want 0", reqCount); end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.dataValid) ndv++;
    end
    checks++; if (ndv != 0) begin errors++; $display("FAIL midfetch_late_data got %0d dataValid want 0", ndv); end
    m_valid = 1'b0; m_count = '0;
  endtask

  initial begin
    test_reset();
    test_request("miss_line5",    32'h0000_0A37, 2);
    test_request("hit_line5",     32'h0000_0A00, 2);
    test_reload();
    test_request("reload_miss",   32'h0000_0A00, 2);
    test_request("out_of_range",  32'(4096 * 512), 2);
    test_request("hit_after_err", 32'h0000_0A37, 2);
    test_request("held_load",     32'h0000_0A00, 10);
    test_request("last_line",     32'h001F_FE00, 2);
    test_request("last_line_hit", 32'h001F_FFFF, 2);
    test_request("max_addr_err",  32'hFFFF_FFFF, 2);
    test_reset_mid_fetch();
    test_request("post_reset",    32'h0000_0E00, 2);
    test_request("post_reset_l5", 32'h0000_0A00, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire

// File: doc/db_line_server.md
# db_line_server

Responder end of the expand engine's database load handshake. It accepts a `load` request carrying a bit-granular database address and converts it to a 512-bit line index. It then fetches that line from the database memory through a fixed-latency read port, or from a one-line hit buffer, and returns it with `loadDone` / `dataValid`. It sits between the seed-extension FSM and the on-chip database RAM.

## Interface
- `MEM_LAT`, 2: database RAM read latency in cycles, ≥1.
- `DB_LINES`, 4096: number of valid 512-bit lines in the database.
- `LINE_AW`, 12: RAM line-address width; `2**LINE_AW` ≥ `DB_LINES`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low (asserted when 0).
- `load` in 1: request from the extension FSM, held high until `loadDone` is seen.
- `addrIn` in 32: database bit address, sampled on request acceptance.
- `dbReload` in 1: database contents changed; invalidates the hit buffer.
- `loadDone` out 1: one-cycle request acknowledge.
- `dataValid` out 1: one-cycle data strobe.
- `dbData` out 512: returned line, stable from `dataValid` until the next `dataValid`.
- `addrErr` out 1: pulses with `dataValid` when the line index is out of range.
- `memRdEn` out 1: RAM read strobe.
- `memRdAddr` out LINE_AW: RAM line address.
- `memRdData` in 512: RAM read data, valid `MEM_LAT` cycles after the `memRdEn` cycle.
- `reqCount` out 16: accepted requests, wraps at 65535→0.

## Operation
- Reset values: `loadDone`=0, `dataValid`=0, `addrErr`=0, `memRdEn`=0, `memRdAddr`=0, `dbData`=0, `reqCount`=0. Hit buffer is invalid; state is IDLE.
- Line index: `line = addrIn[31:9]` (23 bits). The bit offset `addrIn[8:0]` is ignored.
- State machine:
  - **IDLE**: on `load`=1, capture `line`, increment `reqCount`, go to ACK. `load`=0 stays in IDLE.
  - **ACK** (1 cycle): `loadDone`=1.
    - If `line` ≥ `DB_LINES`: `dbData`←0 next edge, go to DATA with error flag.
    - Else if the buffer is valid, its tag equals `line`, and `dbReload`=0 (hit): go to DATA; `dbData` keeps the buffered line.
    - Else (miss): `memRdEn`=1, `memRdAddr`=`line[LINE_AW-1:0]`, go to FETCH.
  - **FETCH**: count `MEM_LAT` cycles from the `memRdEn` cycle. On the final count, register `memRdData` into `dbData`, set tag=`line` and buffer valid, go to DATA.
  - **DATA** (1 cycle): `dataValid`=1; `addrErr`=error flag. If `load`=0 go to IDLE, else go to REARM.
  - **REARM**: wait for `load`=0, then go to IDLE. This stops a request that is still held high from being re-accepted.
- `load` is ignored in all states except IDLE. `addrIn` changes after acceptance have no effect.
- `dbReload`=1 clears buffer valid on that edge in any state. If it coincides with a FETCH completion, the FETCH fill wins and the buffer is valid after that edge. In ACK, a `dbReload` in the same cycle forces a miss.
- An out-of-range request never asserts `memRdEn` and never updates the buffer tag or valid bit.
- Reset during FETCH abandons the read; a late `memRdData` is ignored.

## Timing
- T = cycle in which IDLE samples `load`=1.
- `loadDone` is high in cycle T+1 only.
- Miss: `memRdEn` is high in T+1; `dataValid` is high in T+2+`MEM_LAT`.
- Hit or out-of-range: `dataValid` is high in T+2.
- Requester drops `load` at T+2. The earliest next acceptance is the cycle after DATA.
- Throughput: one request per 3 cycles on hits, per 3+`MEM_LAT` cycles on misses.
- All outputs are registered.

## Test plan
- Reset then miss, `MEM_LAT`=2: `load`=1 with `addrIn`=0x0000_0A37 (line 5), held until `loadDone`, RAM line 5 = pattern A. Expect `loadDone` at T+1, `memRdEn` with `memRdAddr`=5 at T+1, `dataValid` with `dbData`=A at T+4, `addrErr`=0, `reqCount`=1.
- Hit: repeat with `addrIn`=0x0000_0A00. Expect no `memRdEn`, `dataValid` at T+2, `dbData`=A.
- Reload: `dbReload` pulse, then the same request. Expect a miss: `memRdEn` asserted, data at T+4.
- Out of range: `addrIn`=4096×512. Expect no `memRdEn`, `dataValid` and `addrErr`=1 at T+2, `dbData`=0; a following line-5 request is still a hit.
- Held load: keep `load`=1 for 10 cycles. Expect exactly one `loadDone` and one `dataValid`, `reqCount` +1, FSM in REARM until `load` falls.
- Reset mid-FETCH: drive `rst`=0 at T+2 of a miss. Expect all outputs 0, no `dataValid`, next request a miss.
